mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
Multi-cycle main controller; sits directly upstream of the PC register and drives its write enable (PCcontrol) and the next-PC select. It sequences every instruction through IF/ID/EXE/MEM/WB states and emits all datapath write enables and mux selects. PCcontrol pulses exactly once per retired instruction.

Parameters:
OP_W, 6, opcode width
ALUOP_W, 3, ALU operation select width

Ports:
CLK  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset (Reset==0 resets)
opcode  in  6  IR[31:26] from instruction register
zero  in  1  ALU zero flag, valid in EXE
PCcontrol  out  1  PC write enable, one cycle per instruction
PCSrc  out  2  00 PC+4, 01 PC+4+(imm<<2), 10 rs (jr), 11 jump target {PC+4[31:28],addr,2'b00}
IRWre  out  1  instruction register write enable
ExtSel  out  1  1 sign-extend imm, 0 zero-extend
ALUSrcB  out  1  0 rt, 1 extended imm
ALUOp  out  3  000 add, 001 sub, 100 and, 101 or, 110 slt
RegWre  out  1  register file write enable
RegDst  out  2  00 rt, 01 rd, 10 $31
WrRegDSrc  out  1  0 PC+4 (jal), 1 DB bus
DBDataSrc  out  1  0 ALU result, 1 data memory
mRD  out  1  data memory read
mWR  out  1  data memory write
state  out  3  current state
halted  out  1  halt instruction decoded

Behaviour:
- Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, slt 100110, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111; any other = NOP (treated as add with RegWre=0).
- States: sIF 000, sID 001, sEXE_AL 110, sEXE_BR 101, sEXE_LS 010, sMEM 011, sWB_AL 111, sWB_LD 100.
- Transitions: IF->ID always. ID: j/jr/jal->IF; halt->ID (hold); beq/bne->EXE_BR; sw/lw->EXE_LS; else->EXE_AL. EXE_AL->WB_AL->IF. EXE_BR->IF. EXE_LS->MEM. MEM: sw->IF, lw->WB_LD. WB_LD->IF.
- Latency: jumps 2 cycles, branch 3, ALU 4, sw 4, lw 5.
- State register: async clear to sIF on Reset low; updates on posedge CLK.
- All outputs combinational from state/opcode/zero; all forced 0 while Reset==0 (state reads 000).
- IRWre=1 only in sIF. PCcontrol=1 in: ID for j/jr/jal; EXE_BR; MEM for sw; WB_AL; WB_LD. Never in sIF; never while halted.
- PCSrc: ID j/jal 11, jr 10; EXE_BR 01 if (beq&zero)|(bne&~zero) else 00; all other states 00.
- ExtSel=1 for addiu, sw, lw, beq, bne; 0 otherwise. ALUSrcB=1 for addiu, andi, ori, sw, lw.
- ALUOp: sub/beq/bne 001, and/andi 100, ori 101, slt 110, else 000.
- RegWre=1: WB_AL (non-NOP), WB_LD, ID for jal. RegDst: WB_AL R-type 01, I-type 00; WB_LD 00; jal 10.
- WrRegDSrc=0 only for jal in ID. DBDataSrc=1 in MEM(lw) and WB_LD. mRD=1 MEM lw; mWR=1 MEM sw.
- halted=1 while in sID with opcode halt; exit only via Reset.
- Reset mid-instruction: abandon instruction, no write enables, restart in sIF on first clock after release.
- opcode assumed stable from ID through instruction end (IR written only in IF).

Optional Feature:
MC_RETIRE_COUNT_EN: adds output retired[31:0]; async-reset to 0, increments on each posedge where PCcontrol=1, wraps 0xFFFFFFFF->0. Without macro: port and counter absent, behaviour otherwise identical.

Test Plan:
Reset low 3 cycles then high, opcode=add -> states 000,001,110,111,000; PCcontrol=1 only in 111; RegWre=1, RegDst=01 in 111.
lw (110001) -> 000,001,010,011,100,000; mRD=1 in 011; RegWre=1, DBDataSrc=1 in 100; PCcontrol once.
beq with zero=1 -> EXE_BR PCSrc=01, PCcontrol=1; repeat zero=0 -> PCSrc=00; bne inverse.
jal -> ID: PCSrc=11, RegWre=1, RegDst=10, WrRegDSrc=0, PCcontrol=1; next state 000.
halt -> state stays 001 for 10 cycles, halted=1, PCcontrol=0, RegWre=0; Reset pulse low -> state 000.
Reset asserted in sMEM of sw -> mWR drops to 0 immediately, state 000; with MC_RETIRE_COUNT_EN, retired=0.

Source files
------------

// File: rtl/mc_control_unit.sv
//==============================================================================
// Module   : mc_control_unit
// Brief    : Multi-cycle main controller sequencing IF/ID/EXE/MEM/WB and driving
//            the PC write enable, next-PC select and all datapath controls.
//            Optional retired-instruction counter under macro MC_RETIRE_COUNT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mc_control_unit #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               zero,
    output logic               PCcontrol,
    output logic [1:0]         PCSrc,
    output logic               IRWre,
    output logic               ExtSel,
    output logic               ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               RegWre,
    output logic [1:0]         RegDst,
    output logic               WrRegDSrc,
    output logic               DBDataSrc,
    output logic               mRD,
    output logic               mWR,
    output logic [2:0]         state,
    output logic               halted
`ifdef MC_RETIRE_COUNT_EN
    ,
    output logic [31:0]        retired
`endif
);

    localparam logic [2:0] c_S_IF     = 3'b000;
    localparam logic [2:0] c_S_ID     = 3'b001;
    localparam logic [2:0] c_S_EXE_AL = 3'b110;
    localparam logic [2:0] c_S_EXE_BR = 3'b101;
    localparam logic [2:0] c_S_EXE_LS = 3'b010;
    localparam logic [2:0] c_S_MEM    = 3'b011;
    localparam logic [2:0] c_S_WB_AL  = 3'b111;
    localparam logic [2:0] c_S_WB_LD  = 3'b100;

    localparam logic [OP_W-1:0] c_OP_ADD   = 6'b000000;
    localparam logic [OP_W-1:0] c_OP_SUB   = 6'b000001;
    localparam logic [OP_W-1:0] c_OP_ADDIU = 6'b000010;
    localparam logic [OP_W-1:0] c_OP_AND   = 6'b010000;
    localparam logic [OP_W-1:0] c_OP_ANDI  = 6'b010001;
    localparam logic [OP_W-1:0] c_OP_ORI   = 6'b010010;
    localparam logic [OP_W-1:0] c_OP_SLT   = 6'b100110;
    localparam logic [OP_W-1:0] c_OP_SW    = 6'b110000;
    localparam logic [OP_W-1:0] c_OP_LW    = 6'b110001;
    localparam logic [OP_W-1:0] c_OP_BEQ   = 6'b110100;
    localparam logic [OP_W-1:0] c_OP_BNE   = 6'b110101;
    localparam logic [OP_W-1:0] c_OP_J     = 6'b111000;
    localparam logic [OP_W-1:0] c_OP_JR    = 6'b111001;
    localparam logic [OP_W-1:0] c_OP_JAL   = 6'b111010;
    localparam logic [OP_W-1:0] c_OP_HALT  = 6'b111111;

    logic [2:0] state_q;
    logic [2:0] state_d;

    logic w_is_addiu, w_is_andi, w_is_ori, w_is_sw, w_is_lw, w_is_beq, w_is_bne;
    logic w_is_j, w_is_jr, w_is_jal, w_is_halt, w_is_sub, w_is_and, w_is_slt, w_is_add;
    logic w_is_itype, w_is_jump, w_br_taken;

    always_comb begin
        w_is_add   = (opcode == c_OP_ADD);
        w_is_sub   = (opcode == c_OP_SUB);
        w_is_addiu = (opcode == c_OP_ADDIU);
        w_is_and   = (opcode == c_OP_AND);
        w_is_andi  = (opcode == c_OP_ANDI);
        w_is_ori   = (opcode == c_OP_ORI);
        w_is_slt   = (opcode == c_OP_SLT);
        w_is_sw    = (opcode == c_OP_SW);
        w_is_lw    = (opcode == c_OP_LW);
        w_is_beq   = (opcode == c_OP_BEQ);
        w_is_bne   = (opcode == c_OP_BNE);
        w_is_j     = (opcode == c_OP_J);
        w_is_jr    = (opcode == c_OP_JR);
        w_is_jal   = (opcode == c_OP_JAL);
        w_is_halt  = (opcode == c_OP_HALT);
        w_is_itype = w_is_addiu | w_is_andi | w_is_ori;
        w_is_jump  = w_is_j | w_is_jr | w_is_jal;
        w_br_taken = (w_is_beq & zero) | (w_is_bne & ~zero);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= c_S_IF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_IF: state_d = c_S_ID;
            c_S_ID: begin
                if (w_is_jump)                state_d = c_S_IF;
                else if (w_is_halt)           state_d = c_S_ID;
                else if (w_is_beq | w_is_bne) state_d = c_S_EXE_BR;
                else if (w_is_sw | w_is_lw)   state_d = c_S_EXE_LS;
                else                          state_d = c_S_EXE_AL;
            end
            c_S_EXE_AL: state_d = c_S_WB_AL;
            c_S_EXE_BR: state_d = c_S_IF;
            c_S_EXE_LS: state_d = c_S_MEM;
            c_S_MEM:    state_d = w_is_lw ? c_S_WB_LD : c_S_IF;
            c_S_WB_AL:  state_d = c_S_IF;
            c_S_WB_LD:  state_d = c_S_IF;
            default:    state_d = c_S_IF;
        endcase
    end

    // Every output is gated by Reset so a mid-instruction reset drops all enables at once.
    always_comb begin
        PCcontrol = 1'b0;
        PCSrc     = 2'b00;
        IRWre     = 1'b0;
        ExtSel    = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        state     = 3'b000;
        halted    = 1'b0;
        if (Reset) begin
            state     = state_q;
            WrRegDSrc = 1'b1;
            ExtSel    = w_is_addiu | w_is_sw | w_is_lw | w_is_beq | w_is_bne;
            ALUSrcB   = w_is_itype | w_is_sw | w_is_lw;
            if (w_is_sub | w_is_beq | w_is_bne) ALUOp = 3'b001;
            else if (w_is_and | w_is_andi)      ALUOp = 3'b100;
            else if (w_is_ori)                  ALUOp = 3'b101;
            else if (w_is_slt)                  ALUOp = 3'b110;
            case (state_q)
                c_S_IF: IRWre = 1'b1;
                c_S_ID: begin
                    halted = w_is_halt;
                    if (w_is_jump) PCcontrol = 1'b1;
                    if (w_is_j | w_is_jal) PCSrc = 2'b11;
                    else if (w_is_jr)      PCSrc = 2'b10;
                    if (w_is_jal) begin
                        RegWre    = 1'b1;
                        RegDst    = 2'b10;
                        WrRegDSrc = 1'b0;
                    end
                end
                c_S_EXE_BR: begin
                    PCcontrol = 1'b1;
                    PCSrc     = w_br_taken ? 2'b01 : 2'b00;
                end
                c_S_MEM: begin
                    PCcontrol = w_is_sw;
                    mWR       = w_is_sw;
                    mRD       = w_is_lw;
                    DBDataSrc = w_is_lw;
                end
                c_S_WB_AL: begin
                    // Unlisted opcodes flow through as an add that never writes back.
                    PCcontrol = 1'b1;
                    RegWre    = w_is_add | w_is_sub | w_is_and | w_is_slt | w_is_itype;
                    RegDst    = w_is_itype ? 2'b00 : 2'b01;
                end
                c_S_WB_LD: begin
                    PCcontrol = 1'b1;
                    RegWre    = 1'b1;
                    DBDataSrc = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_RETIRE_COUNT_EN
    logic [31:0] retired_q;
    logic [31:0] retired_d;

    always_comb begin
        retired_d = retired_q + {31'd0, PCcontrol};
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) retired_q <= 32'd0;
        else        retired_q <= retired_d;
    end

    assign retired = retired_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
//==============================================================================
// Module   : tb_mc_control_unit
// Brief    : Directed self-checking bench for mc_control_unit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mc_control_unit;

    logic       CLK;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero;
    logic       PCcontrol;
    logic [1:0] PCSrc;
    logic       IRWre;
    logic       ExtSel;
    logic       ALUSrcB;
    logic [2:0] ALUOp;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       mRD;
    logic       mWR;
    logic [2:0] state;
    logic       halted;
`ifdef MC_RETIRE_COUNT_EN
    logic [31:0] retired;
`endif

    int checks = 0;
    int errors = 0;

    mc_control_unit #(.OP_W(6), .ALUOP_W(3)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .opcode    (opcode),
        .zero      (zero),
        .PCcontrol (PCcontrol),
        .PCSrc     (PCSrc),
        .IRWre     (IRWre),
        .ExtSel    (ExtSel),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .RegWre    (RegWre),
        .RegDst    (RegDst),
        .WrRegDSrc (WrRegDSrc),
        .DBDataSrc (DBDataSrc),
        .mRD       (mRD),
        .mWR       (mWR),
        .state     (state),
        .halted    (halted)
`ifdef MC_RETIRE_COUNT_EN
        ,
        .retired   (retired)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset  = 1'b0;
        opcode = 6'b000000;
        zero   = 1'b0;

        // Reset held low: everything forced to zero.
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_state", state, 3'b000);
        chk("rst_irwre", IRWre, 0);
        chk("rst_wrregdsrc", WrRegDSrc, 0);
        chk("rst_pcctl", PCcontrol, 0);

        // add: 000,001,110,111,000
        Reset = 1'b1;
        #1;
        chk("add_if_state", state, 3'b000);
        chk("add_if_irwre", IRWre, 1);
        chk("add_if_pcctl", PCcontrol, 0);
        tick();
        chk("add_id_state", state, 3'b001);
        chk("add_id_pcctl", PCcontrol, 0);
        chk("add_id_irwre", IRWre, 0);
        tick();
        chk("add_exe_state", state, 3'b110);
        chk("add_exe_pcctl", PCcontrol, 0);
        chk("add_exe_regwre", RegWre, 0);
        tick();
        chk("add_wb_state", state, 3'b111);
        chk("add_wb_pcctl", PCcontrol, 1);
        chk("add_wb_regwre", RegWre, 1);
        chk("add_wb_regdst", RegDst, 2'b01);
        tick();
        chk("add_end_state", state, 3'b000);

        // lw: 000,001,010,011,100,000
        opcode = 6'b110001;
        #1;
        chk("lw_extsel", ExtSel, 1);
        chk("lw_alusrcb", ALUSrcB, 1);
        tick();
        chk("lw_id_state", state, 3'b001);
        tick();
        chk("lw_exe_state", state, 3'b010);
        chk("lw_exe_pcctl", PCcontrol, 0);
        tick();
        chk("lw_mem_state", state, 3'b011);
        chk("lw_mem_mrd", mRD, 1);
        chk("lw_mem_mwr", mWR, 0);
        chk("lw_mem_dbsrc", DBDataSrc, 1);
        chk("lw_mem_pcctl", PCcontrol, 0);
        tick();
        chk("lw_wb_state", state, 3'b100);
        chk("lw_wb_regwre", RegWre, 1);
        chk("lw_wb_dbsrc", DBDataSrc, 1);
        chk("lw_wb_regdst", RegDst, 2'b00);
        chk("lw_wb_pcctl", PCcontrol, 1);
        tick();
        chk("lw_end_state", state, 3'b000);

        // beq: taken with zero=1, not taken with zero=0
        opcode = 6'b110100;
        zero   = 1'b1;
        tick();
        tick();
        chk("beq_state", state, 3'b101);
        chk("beq_aluop", ALUOp, 3'b001);
        chk("beq_z1_pcsrc", PCSrc, 2'b01);
        chk("beq_z1_pcctl", PCcontrol, 1);
        zero = 1'b0;
        #1;
        chk("beq_z0_pcsrc", PCSrc, 2'b00);
        chk("beq_z0_pcctl", PCcontrol, 1);
        tick();
        chk("beq_end_state", state, 3'b000);

        // bne: inverse sense
        opcode = 6'b110101;
        tick();
        tick();
        chk("bne_state", state, 3'b101);
        chk("bne_z0_pcsrc", PCSrc, 2'b01);
        zero = 1'b1;
        #1;
        chk("bne_z1_pcsrc", PCSrc, 2'b00);
        tick();
        chk("bne_end_state", state, 3'b000);
        zero = 1'b0;

        // jal completes in ID
        opcode = 6'b111010;
        tick();
        chk("jal_state", state, 3'b001);
        chk("jal_pcsrc", PCSrc, 2'b11);
        chk("jal_regwre", RegWre, 1);
        chk("jal_regdst", RegDst, 2'b10);
        chk("jal_wrregdsrc", WrRegDSrc, 0);
        chk("jal_pcctl", PCcontrol, 1);
        tick();
        chk("jal_end_state", state, 3'b000);

        // jr
        opcode = 6'b111001;
        tick();
        chk("jr_pcsrc", PCSrc, 2'b10);
        chk("jr_regwre", RegWre, 0);
        chk("jr_wrregdsrc", WrRegDSrc, 1);
        tick();
        chk("jr_end_state", state, 3'b000);

        // ori: I-type write-back to rt
        opcode = 6'b010010;
        tick();
        tick();
        chk("ori_aluop", ALUOp, 3'b101);
        chk("ori_extsel", ExtSel, 0);
        tick();
        chk("ori_wb_state", state, 3'b111);
        chk("ori_wb_regwre", RegWre, 1);
        chk("ori_wb_regdst", RegDst, 2'b00);
        tick();

        // NOP (undefined opcode): add path without register write
        opcode = 6'b000011;
        tick();
        tick();
        chk("nop_exe_state", state, 3'b110);
        tick();
        chk("nop_wb_state", state, 3'b111);
        chk("nop_wb_regwre", RegWre, 0);
        chk("nop_wb_pcctl", PCcontrol, 1);
        tick();
        chk("nop_end_state", state, 3'b000);

        // sw, reset asserted in MEM
        opcode = 6'b110000;
        tick();
        tick();
        chk("sw_exe_state", state, 3'b010);
        tick();
        chk("sw_mem_state", state, 3'b011);
        chk("sw_mem_mwr", mWR, 1);
        chk("sw_mem_pcctl", PCcontrol, 1);
        Reset = 1'b0;
        #1;
        chk("sw_rst_mwr", mWR, 0);
        chk("sw_rst_state", state, 3'b000);
        chk("sw_rst_pcctl", PCcontrol, 0);
`ifdef MC_RETIRE_COUNT_EN
        chk("sw_rst_retired", retired, 32'd0);
`endif
        Reset = 1'b1;
        #1;
        chk("sw_rel_state", state, 3'b000);
        tick();
        chk("sw_rel_id_state", state, 3'b001);

        // halt: hold in ID until reset
        opcode = 6'b111111;
        #1;
        chk("halt_halted", halted, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_hold_state", state, 3'b001);
            chk("halt_hold_halted", halted, 1);
            chk("halt_hold_pcctl", PCcontrol, 0);
            chk("halt_hold_regwre", RegWre, 0);
        end
        Reset = 1'b0;
        #1;
        chk("halt_rst_state", state, 3'b000);
        chk("halt_rst_halted", halted, 0);
        tick();
        Reset = 1'b1;
        #1;
        chk("halt_rel_state", state, 3'b000);
        chk("halt_rel_irwre", IRWre, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
